// File: rtl/phv_assembler_pkg.sv
// phv_assembler_pkg: PHV geometry shared by the assembler and its FIFO.
//   PHV layout, MSB first: 8x6B containers, 8x4B, 8x2B, then the 356-bit remain field.
package phv_assembler_pkg;
  localparam int W_6B     = 48;
  localparam int W_4B     = 32;
  localparam int W_2B     = 16;
  localparam int N_6B     = 8;
  localparam int N_4B     = 8;
  localparam int N_2B     = 8;
  localparam int REMAIN_W = 5 * 20 + 256;
  localparam int OFF_REM  = 0;
  localparam int OFF_2B   = OFF_REM + REMAIN_W;
  localparam int OFF_4B   = OFF_2B + W_2B * N_2B;
  localparam int OFF_6B   = OFF_4B + W_4B * N_4B;
  localparam int PHV_W    = OFF_6B + W_6B * N_6B;
endpackage

// File: rtl/phv_assembler_remain_fifo.sv
// remain_fifo: synchronous FIFO whose head entry reads out combinationally.
//   clk, rst_n     clock, async active-low reset (pointers only)
//   push, din      write request and data; ignored when full unless popping
//   pop            remove the head entry; ignored when empty
//   head           oldest entry, valid while empty=0
//   full, empty    occupancy status
module remain_fifo #(
  parameter int WIDTH = 356,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  logic do_push, do_pop;
  assign empty   = wr == rd;
  assign full    = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
    end else begin
      wr <= wr + (AW+1)'(do_push);
      rd <= rd + (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/phv_assembler.sv
// phv_assembler: rebuilds the PHV from the three ALU result groups and the queued remain field.
//   remain_in/_valid          pass-through field from the crossbar, queued in a FIFO
//   alu_out_{6B,4B,2B}/_valid ALU result groups, each held in a slot until merged
//   phv_out/_valid/_ready     rebuilt PHV toward the next stage, valid/ready handshake
//   err_group_ovf             sticky: group result arrived while its slot was full
//   err_fifo_ovf              sticky: remain push dropped because the FIFO was full
//   err_fifo_udf              all groups collected but FIFO empty for 8 cycles
module phv_assembler
  import phv_assembler_pkg::*;
#(
  parameter int STAGE      = 0,
  parameter int PHV_LEN    = PHV_W,
  parameter int REMAIN_LEN = REMAIN_W,
  parameter int width_6B   = W_6B,
  parameter int width_4B   = W_4B,
  parameter int width_2B   = W_2B,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REMAIN_LEN-1:0] remain_in,
  input  logic                  remain_in_valid,
  input  logic [width_6B*8-1:0] alu_out_6B,
  input  logic                  alu_out_6B_valid,
  input  logic [width_4B*8-1:0] alu_out_4B,
  input  logic                  alu_out_4B_valid,
  input  logic [width_2B*8-1:0] alu_out_2B,
  input  logic                  alu_out_2B_valid,
  output logic [PHV_LEN-1:0]    phv_out,
  output logic                  phv_out_valid,
  input  logic                  phv_out_ready,
  output logic                  err_group_ovf,
  output logic                  err_fifo_ovf,
  output logic                  err_fifo_udf
);
  logic [31:0] unused_stage;
  assign unused_stage = STAGE;
  logic [width_6B*8-1:0] slot_6b;
  logic [width_4B*8-1:0] slot_4b;
  logic [width_2B*8-1:0] slot_2b;
  logic got_6b, got_4b, got_2b, all_got, merge;
  logic cap_6b, cap_4b, cap_2b, full, empty, wd_run;
  logic [REMAIN_LEN-1:0] head;
  logic [2:0] wd_cnt;
  remain_fifo #(.WIDTH(REMAIN_LEN), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (remain_in_valid),
    .pop   (merge),
    .din   (remain_in),
    .head  (head),
    .full  (full),
    .empty (empty)
  );
  assign all_got = got_6b && got_4b && got_2b;
  assign merge   = all_got && !empty && (!phv_out_valid || phv_out_ready);
  // A merge frees every slot on the same edge, so a new result is always accepted then.
  assign cap_6b  = alu_out_6B_valid && (!got_6b || merge);
  assign cap_4b  = alu_out_4B_valid && (!got_4b || merge);
  assign cap_2b  = alu_out_2B_valid && (!got_2b || merge);
  assign wd_run  = all_got && empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot_6b       <= '0;
      slot_4b       <= '0;
      slot_2b       <= '0;
      got_6b        <= 1'b0;
      got_4b        <= 1'b0;
      got_2b        <= 1'b0;
      phv_out       <= '0;
      phv_out_valid <= 1'b0;
      wd_cnt        <= '0;
      err_group_ovf <= 1'b0;
      err_fifo_ovf  <= 1'b0;
      err_fifo_udf  <= 1'b0;
    end else begin
      if (cap_6b) slot_6b <= alu_out_6B;
      if (cap_4b) slot_4b <= alu_out_4B;
      if (cap_2b) slot_2b <= alu_out_2B;
      got_6b <= cap_6b || (got_6b && !merge);
      got_4b <= cap_4b || (got_4b && !merge);
      got_2b <= cap_2b || (got_2b && !merge);
      if (merge) phv_out <= {slot_6b, slot_4b, slot_2b, head};
      phv_out_valid <= merge || (phv_out_valid && !phv_out_ready);
      wd_cnt        <= wd_run ? (wd_cnt == 3'd7 ? wd_cnt : wd_cnt + 3'd1) : 3'd0;
      err_fifo_udf  <= wd_run && wd_cnt == 3'd7;
      err_group_ovf <= err_group_ovf || (!merge &&
                       ((alu_out_6B_valid && got_6b) || (alu_out_4B_valid && got_4b) ||
                        (alu_out_2B_valid && got_2b)));
      err_fifo_ovf  <= err_fifo_ovf || (remain_in_valid && full && !merge);
    end
endmodule
